// File: rtl/proc_pkg.sv
// Shared encodings for the 16-bit bus processor control path.
package proc_pkg;

    // Controller sequencing steps; T0 is the fetch step
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // Opcode field IR[8:6]; values 5..7 are undefined
    localparam logic [2:0] MV   = 3'd0;
    localparam logic [2:0] MVI  = 3'd1;
    localparam logic [2:0] ADD  = 3'd2;
    localparam logic [2:0] SUB  = 3'd3;
    localparam logic [2:0] MVNZ = 3'd4;

    // ALU mode driven on AddSub
    localparam logic ADDSUB_ADD = 1'b0;
    localparam logic ADDSUB_SUB = 1'b1;

endpackage

// File: rtl/proc_ctrl_if.sv
// Handshake and datapath control signals between controller and datapath.
interface proc_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             Run;
    logic [8:0]       IR;
    logic             GZero;
    logic             IRin;
    logic [7:0]       Rin;
    logic [7:0]       Rout;
    logic             DINout;
    logic             Gout;
    logic             Ain;
    logic             Gin;
    logic             AddSub;
    logic             Done;
    logic             Illegal;
    logic [CNT_W-1:0] InstrCount;

    // Datapath / outside world side
    modport master (
        output Run, IR, GZero,
        input  IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Illegal, InstrCount
    );

    // Controller side
    modport slave (
        input  Run, IR, GZero,
        output IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Illegal, InstrCount
    );
endinterface

// File: rtl/proc_ctrl_dec3to8.sv
// 3-to-8 one-hot decoder with enable.
module dec3to8 (
    input  logic [2:0] W,
    input  logic       En,
    output logic [7:0] Y
);

    // One-hot decode of W when enabled
    always_comb begin
        Y = '0;
        if (En) Y[W] = 1'b1;
    end

endmodule

// File: rtl/proc_ctrl.sv
// Control unit: fetch/decode sequencing, datapath control and retired-instruction count.
module proc_ctrl
    import proc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    proc_ctrl_if.slave    bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       op;
    logic [7:0]       x_oh, y_oh;

    logic       irin, dinout, gout, ain, gin, addsub, done, illegal;
    logic [7:0] rin, rout;

    assign op = bus.IR[8:6];

    dec3to8 u_dec_x (.W(bus.IR[5:3]), .En(1'b1), .Y(x_oh));
    dec3to8 u_dec_y (.W(bus.IR[2:0]), .En(1'b1), .Y(y_oh));

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state_q <= T0;
        else       state_q <= state_d;
    end

    // Retired-instruction counter register
    always_ff @(posedge Clock) begin
        if (Reset) count_q <= '0;
        else       count_q <= count_d;
    end

    // Next-state and control decode; Reset masks every output last
    always_comb begin
        state_d = state_q;
        irin    = 1'b0;
        rin     = '0;
        rout    = '0;
        dinout  = 1'b0;
        gout    = 1'b0;
        ain     = 1'b0;
        gin     = 1'b0;
        addsub  = ADDSUB_ADD;
        done    = 1'b0;
        illegal = 1'b0;
        unique case (state_q)
            T0: begin
                irin = bus.Run;
                if (bus.Run) state_d = T1;
            end
            T1: begin
                case (op)
                    MV: begin
                        rout    = y_oh;
                        rin     = x_oh;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    MVI: begin
                        dinout  = 1'b1;
                        rin     = x_oh;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    ADD, SUB: begin
                        rout    = x_oh;
                        ain     = 1'b1;
                        state_d = T2;
                    end
                    MVNZ: begin
                        if (!bus.GZero) begin
                            rout = y_oh;
                            rin  = x_oh;
                        end
                        done    = 1'b1;
                        state_d = T0;
                    end
                    default: begin
                        done    = 1'b1;
                        illegal = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                rout    = y_oh;
                gin     = 1'b1;
                addsub  = (op == SUB) ? ADDSUB_SUB : ADDSUB_ADD;
                state_d = T3;
            end
            T3: begin
                gout    = 1'b1;
                rin     = x_oh;
                done    = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
        count_d = count_q + CNT_W'(done);
        if (Reset) begin
            irin    = 1'b0;
            rin     = '0;
            rout    = '0;
            dinout  = 1'b0;
            gout    = 1'b0;
            ain     = 1'b0;
            gin     = 1'b0;
            addsub  = 1'b0;
            done    = 1'b0;
            illegal = 1'b0;
        end
    end

    assign bus.IRin       = irin;
    assign bus.Rin        = rin;
    assign bus.Rout       = rout;
    assign bus.DINout     = dinout;
    assign bus.Gout       = gout;
    assign bus.Ain        = ain;
    assign bus.Gin        = gin;
    assign bus.AddSub     = addsub;
    assign bus.Done       = done;
    assign bus.Illegal    = illegal;
    assign bus.InstrCount = Reset ? '0 : count_q;

endmodule

// File: tb/tb_proc_ctrl.sv
// Scoreboard bench for proc_ctrl: driver queues per-cycle expectations, monitor checks them.
module tb_proc_ctrl;

    typedef struct packed {
        logic        irin;
        logic [7:0]  rin;
        logic [7:0]  rout;
        logic        din;
        logic        gout;
        logic        ain;
        logic        gin;
        logic        addsub;
        logic        done;
        logic        ill;
        logic [15:0] cnt;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset;

    proc_ctrl_if #(.CNT_W(16)) bus ();
    proc_ctrl_if #(.CNT_W(2))  bus_s ();

    proc_ctrl #(.CNT_W(16)) dut   (.Clock(Clock), .Reset(Reset), .bus(bus));
    proc_ctrl #(.CNT_W(2))  dut_s (.Clock(Clock), .Reset(Reset), .bus(bus_s));

    assign bus_s.Run   = bus.Run;
    assign bus_s.IR    = bus.IR;
    assign bus_s.GZero = bus.GZero;

    always #5 Clock = ~Clock;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;

    function automatic exp_t mk(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                                input logic din, input logic gout, input logic ain, input logic gin,
                                input logic addsub, input logic done, input logic ill,
                                input logic [15:0] cnt);
        exp_t e;
        e.irin = irin; e.rin = rin; e.rout = rout; e.din = din; e.gout = gout;
        e.ain = ain; e.gin = gin; e.addsub = addsub; e.done = done; e.ill = ill; e.cnt = cnt;
        return e;
    endfunction

    // Drive one cycle of inputs, queue the expected outputs, advance to just after next edge
    task automatic cyc(input logic rst, input logic run, input logic [8:0] ir, input logic gz,
                       input exp_t e);
        Reset     = rst;
        bus.Run   = run;
        bus.IR    = ir;
        bus.GZero = gz;
        sb.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    always @(negedge Clock) begin
        exp_t e, a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {bus.IRin, bus.Rin, bus.Rout, bus.DINout, bus.Gout, bus.Ain, bus.Gin,
                 bus.AddSub, bus.Done, bus.Illegal, bus.InstrCount};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL ctrl_outputs cyc%0d: got irin=%b rin=%h rout=%h din=%b gout=%b ain=%b gin=%b as=%b done=%b ill=%b cnt=%0d ; expected irin=%b rin=%h rout=%h din=%b gout=%b ain=%b gin=%b as=%b done=%b ill=%b cnt=%0d",
                         cyc_no, a.irin, a.rin, a.rout, a.din, a.gout, a.ain, a.gin, a.addsub, a.done, a.ill, a.cnt,
                         e.irin, e.rin, e.rout, e.din, e.gout, e.ain, e.gin, e.addsub, e.done, e.ill, e.cnt);
            end
            n_checks++;
            if (bus_s.InstrCount !== e.cnt[1:0]) begin
                n_fail++;
                $display("FAIL small_count_wrap cyc%0d: got %0d expected %0d", cyc_no, bus_s.InstrCount, e.cnt[1:0]);
            end
            n_checks++;
            if (!$onehot0({bus.Rout, bus.DINout, bus.Gout})) begin
                n_fail++;
                $display("FAIL bus_single_driver cyc%0d: got rout=%h din=%b gout=%b expected at most one source",
                         cyc_no, bus.Rout, bus.DINout, bus.Gout);
            end
            cyc_no++;
        end
    end

    initial begin
        Reset     = 1'b1;
        bus.Run   = 1'b1;
        bus.IR    = 9'h000;
        bus.GZero = 1'b0;
        @(posedge Clock);
        #1;
        //      rst run IR     gz      irin rin    rout   din gout ain gin as done ill cnt
        // Reset with Run high: everything held low
        repeat (3) cyc(1, 1, 9'h000, 0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
        // MVI R2
        cyc(0, 1, 9'h050, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(0, 0, 9'h050, 0, mk(0, 8'h04, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0));
        cyc(0, 0, 9'h050, 0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1));
        // ADD R1,R2
        cyc(0, 1, 9'h08A, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(0, 0, 9'h08A, 0, mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 0, 1));
        cyc(0, 1, 9'h08A, 0, mk(0, 8'h00, 8'h04, 0, 0, 0, 1, 0, 0, 0, 1));
        cyc(0, 0, 9'h08A, 0, mk(0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1, 0, 1));
        // SUB R3,R4 with Run held high, then MV R5,R6 back to back
        cyc(0, 1, 9'h0DC, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 2));
        cyc(0, 1, 9'h0DC, 0, mk(0, 8'h00, 8'h08, 0, 0, 1, 0, 0, 0, 0, 2));
        cyc(0, 1, 9'h0DC, 0, mk(0, 8'h00, 8'h10, 0, 0, 0, 1, 1, 0, 0, 2));
        cyc(0, 1, 9'h0DC, 0, mk(0, 8'h08, 8'h00, 0, 1, 0, 0, 0, 1, 0, 2));
        cyc(0, 1, 9'h02E, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 3));
        cyc(0, 0, 9'h02E, 0, mk(0, 8'h20, 8'h40, 0, 0, 0, 0, 0, 1, 0, 3));
        // MVNZ R0,R1 with G zero, then with G nonzero
        cyc(0, 1, 9'h101, 1, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4));
        cyc(0, 0, 9'h101, 1, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0, 4));
        cyc(0, 1, 9'h101, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 5));
        cyc(0, 0, 9'h101, 0, mk(0, 8'h01, 8'h02, 0, 0, 0, 0, 0, 1, 0, 5));
        // Undefined opcode
        cyc(0, 1, 9'h1C0, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 6));
        cyc(0, 0, 9'h1C0, 0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1, 6));
        // MV R3,R3
        cyc(0, 1, 9'h01B, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 7));
        cyc(0, 0, 9'h01B, 0, mk(0, 8'h08, 8'h08, 0, 0, 0, 0, 0, 1, 0, 7));
        // ADD aborted by Reset in T2
        cyc(0, 1, 9'h08A, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8));
        cyc(0, 0, 9'h08A, 0, mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 0, 8));
        cyc(1, 0, 9'h08A, 0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(0, 0, 9'h08A, 0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(0, 1, 9'h050, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(0, 0, 9'h050, 0, mk(0, 8'h04, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0));
        cyc(0, 0, 9'h050, 0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1));

        repeat (5) begin
            if (sb.size() > 0) @(negedge Clock);
        end
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
